// File: rtl/ber_checker.sv
// ber_checker: symbol-rate BER checker. Slices each decimated sample to a bit, sweeps every
// candidate delay of the TX reference PRBS over a fixed window, locks onto the delay with the
// fewest errors (lowest delay on ties), then counts compared bits and bit errors.
// All state advances only on i_en, the same symbol strobe that drives the downsampler.
module ber_checker #(
    parameter int NBT_IN_OUT = 8,
    parameter int NB_DELAY   = 9,
    parameter int WIN_LEN    = 511,
    parameter int NB_CNT     = 64
) (
    input  logic                         clk,
    input  logic                         i_reset,
    input  logic                         i_en,
    input  logic signed [NBT_IN_OUT-1:0] i_is_data,
    input  logic                         i_ref_bit,
    output logic                         o_det_bit,
    output logic                         o_locked,
    output logic        [NB_DELAY-1:0]   o_delay,
    output logic        [NB_CNT-1:0]     o_bit_cnt,
    output logic        [NB_CNT-1:0]     o_err_cnt
);

    localparam int NUM_CAND = 2 ** NB_DELAY;
    localparam int LINE_LEN = NUM_CAND - 1;
    localparam int NB_WIN   = $clog2(WIN_LEN + 1);
    localparam int NB_WC    = $clog2(WIN_LEN);

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]          r_state;
    logic [LINE_LEN-1:0] r_ref_line;
    logic [NB_DELAY-1:0] r_cand;
    logic [NB_WC-1:0]    r_win_cnt;
    logic [NB_WIN-1:0]   r_win_err;
    logic [NB_WIN-1:0]   r_best_err;
    logic [NB_DELAY-1:0] r_best_delay;
    logic [NB_DELAY-1:0] r_delay;
    logic                r_det;
    logic [NB_CNT-1:0]   r_bit_cnt;
    logic [NB_CNT-1:0]   r_err_cnt;

    logic [NUM_CAND-1:0] w_taps;
    logic [NB_DELAY-1:0] w_sel;
    logic                w_det;
    logic                w_err;
    logic [NB_WIN-1:0]   w_tot;
    logic                w_last;
    logic                w_better;
    logic [NB_DELAY-1:0] w_best_nxt;
    logic                w_locked;
    logic                w_sat;

    // Slicer, tap select and window bookkeeping
    always_comb begin
        w_det      = ~i_is_data[NBT_IN_OUT-1];
        // w_taps[0] is the live ref bit, w_taps[d] is the ref bit d enables ago
        w_taps     = {r_ref_line, i_ref_bit};
        w_locked   = (r_state == ST_LOCKED);
        w_sel      = w_locked ? r_delay : r_cand;
        w_err      = w_det ^ w_taps[w_sel];
        w_tot      = r_win_err + {{(NB_WIN-1){1'b0}}, w_err};
        w_last     = (r_win_cnt == NB_WC'(WIN_LEN - 1));
        w_better   = (w_tot < r_best_err);
        w_best_nxt = w_better ? r_cand : r_best_delay;
        w_sat      = &r_bit_cnt;
    end

    // Reference delay line, newest bit at index 0
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_ref_line <= '0;
        end else if (i_en) begin
            r_ref_line <= {r_ref_line[LINE_LEN-2:0], i_ref_bit};
        end
    end

    // Registered sliced bit, updated in both states
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_det <= 1'b0;
        end else if (i_en) begin
            r_det <= w_det;
        end
    end

    // Delay search FSM; LOCKED is absorbing until reset
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state      <= ST_SEARCH;
            r_cand       <= '0;
            r_win_cnt    <= '0;
            r_win_err    <= '0;
            r_best_err   <= '1;
            r_best_delay <= '0;
            r_delay      <= '0;
        end else if (i_en && !w_locked) begin
            if (w_last) begin
                r_win_cnt <= '0;
                r_win_err <= '0;
                if (w_better) begin
                    r_best_err   <= w_tot;
                    r_best_delay <= r_cand;
                end
                if (r_cand == {NB_DELAY{1'b1}}) begin
                    r_state <= ST_LOCKED;
                    // Includes the window finishing this cycle
                    r_delay <= w_best_nxt;
                end else begin
                    r_cand <= r_cand + NB_DELAY'(1);
                end
            end else begin
                r_win_cnt <= r_win_cnt + NB_WC'(1);
                r_win_err <= w_tot;
            end
        end
    end

    // Bit/error counters; both freeze together once bit count saturates
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_bit_cnt <= '0;
            r_err_cnt <= '0;
        end else if (i_en && w_locked && !w_sat) begin
            r_bit_cnt <= r_bit_cnt + NB_CNT'(1);
            r_err_cnt <= r_err_cnt + NB_CNT'(w_err);
        end
    end

    assign o_det_bit = r_det;
    assign o_locked  = w_locked;
    assign o_delay   = r_delay;
    assign o_bit_cnt = r_bit_cnt;
    assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_ber_checker.sv
// Bench for ber_checker with reduced parameters so each search is short. Random symbols
// and strobes are scored against a model that keeps the full per-enable history and
// picks the best delay by brute-force window sums at the end of the search.
module tb_ber_checker;

    localparam int NBT      = 8;
    localparam int NBD      = 3;
    localparam int WIN      = 6;
    localparam int NC       = 6;
    localparam int NCAND    = 2 ** NBD;
    localparam int SRCH_LEN = NCAND * WIN;
    localparam int CMAX     = 2 ** NC - 1;

    typedef struct packed {
        logic           det;
        logic           locked;
        logic [NBD-1:0] delay;
        logic [NC-1:0]  bitc;
        logic [NC-1:0]  errc;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  i_reset = 1'b1;
    logic                  i_en = 1'b0;
    logic signed [NBT-1:0] i_is_data = '0;
    logic                  i_ref_bit = 1'b0;
    logic                  o_det_bit;
    logic                  o_locked;
    logic [NBD-1:0]        o_delay;
    logic [NC-1:0]         o_bit_cnt;
    logic [NC-1:0]         o_err_cnt;

    int total = 0;
    int bad   = 0;

    exp_t sb[$];

    // Model state, indexed by enable number since last reset
    bit det_h[$];
    bit ref_h[$];
    bit g_ref[$];
    bit m_det;
    bit m_locked;
    int m_delay;
    int m_bits;
    int m_errs;

    ber_checker #(
        .NBT_IN_OUT(NBT),
        .NB_DELAY  (NBD),
        .WIN_LEN   (WIN),
        .NB_CNT    (NC)
    ) dut (
        .clk      (clk),
        .i_reset  (i_reset),
        .i_en     (i_en),
        .i_is_data(i_is_data),
        .i_ref_bit(i_ref_bit),
        .o_det_bit(o_det_bit),
        .o_locked (o_locked),
        .o_delay  (o_delay),
        .o_bit_cnt(o_bit_cnt),
        .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit ref_at(input int i);
        if (i < 0) return 1'b0;
        return ref_h[i];
    endfunction

    // Advance the model by one clock with the given inputs
    task automatic model_cycle(input bit rst, input bit en, input logic signed [NBT-1:0] d,
                               input bit rb);
        int k;
        int best;
        int best_e;
        int e;
        bit dt;
        if (rst) begin
            det_h.delete();
            ref_h.delete();
            m_det = 0; m_locked = 0; m_delay = 0; m_bits = 0; m_errs = 0;
        end else if (en) begin
            dt = (d >= 0);
            k  = ref_h.size();
            ref_h.push_back(rb);
            det_h.push_back(dt);
            m_det = dt;
            if (m_locked) begin
                if (m_bits != CMAX) begin
                    m_bits++;
                    m_errs += int'(dt ^ ref_at(k - m_delay));
                end
            end else if (k == SRCH_LEN - 1) begin
                best = 0;
                best_e = WIN + 1;
                for (int c = 0; c < NCAND; c++) begin
                    e = 0;
                    for (int j = 0; j < WIN; j++)
                        e += int'(det_h[c*WIN + j] ^ ref_at(c*WIN + j - c));
                    if (e < best_e) begin
                        best_e = e;
                        best = c;
                    end
                end
                m_locked = 1;
                m_delay = best;
            end
        end
    endtask

    task automatic step(input bit rst, input bit en, input logic signed [NBT-1:0] d,
                        input bit rb);
        exp_t x;
        @(negedge clk);
        i_reset = rst; i_en = en; i_is_data = d; i_ref_bit = rb;
        model_cycle(rst, en, d, rb);
        x.det = m_det; x.locked = m_locked; x.delay = NBD'(m_delay);
        x.bitc = NC'(m_bits); x.errc = NC'(m_errs);
        sb.push_back(x);
    endtask

    task automatic do_reset(input bit en);
        g_ref.delete();
        step(1'b1, en, 8'sd100, 1'b1);
    endtask

    // mode 0: data follows ref delayed by td with noise_pct sign flips; mode 1: ref=1, data=0
    task automatic run(input int n_en, input int td, input int noise_pct, input int en_pct,
                       input int mode);
        int done = 0;
        int idx;
        bit rb;
        bit tgt;
        logic signed [NBT-1:0] d;
        logic signed [NBT-1:0] hold_d = 0;
        bit hold_r = 0;
        while (done < n_en) begin
            if ($urandom_range(0, 99) < en_pct) begin
                if (mode == 1) begin
                    rb = 1'b1;
                    d = 0;
                end else begin
                    rb = 1'($urandom);
                    g_ref.push_back(rb);
                    idx = g_ref.size() - 1 - td;
                    tgt = (idx >= 0) ? g_ref[idx] : 1'b0;
                    if ($urandom_range(0, 99) < noise_pct) tgt = ~tgt;
                    if (tgt && $urandom_range(0, 9) == 0) d = 0;
                    else d = tgt ? NBT'($urandom_range(1, 127))
                                 : -NBT'($urandom_range(1, 128));
                end
                hold_d = d; hold_r = rb;
                step(1'b0, 1'b1, d, rb);
                done++;
            end else begin
                step(1'b0, 1'b0, hold_d, hold_r);
            end
        end
    endtask

    // Monitor: every clock the DUT presents a fresh output set; compare against scoreboard
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            total++;
            if (o_det_bit !== x.det || o_locked !== x.locked || o_delay !== x.delay ||
                o_bit_cnt !== x.bitc || o_err_cnt !== x.errc) begin
                bad++;
                $display("FAIL outputs t=%0t got det=%b lock=%b dly=%0d bits=%0d errs=%0d req det=%b lock=%b dly=%0d bits=%0d errs=%0d",
                         $time, o_det_bit, o_locked, o_delay, o_bit_cnt, o_err_cnt,
                         x.det, x.locked, x.delay, x.bitc, x.errc);
            end
        end
    end

    initial begin
        do_reset(1'b1);
        do_reset(1'b1);
        // Full-rate lock, then some counting
        run(SRCH_LEN + 40, 5, 5, 100, 0);
        // Reset mid-search, with i_en high in the reset cycle
        do_reset(1'b1);
        run(20, 5, 5, 100, 0);
        do_reset(1'b1);
        // Sparse strobe, run past counter saturation
        run(SRCH_LEN + CMAX + 20, 2, 10, 25, 0);
        // Reset after lock, then slicer/tie case
        do_reset(1'b0);
        run(SRCH_LEN + 20, 0, 0, 70, 1);
        do_reset(1'b0);
        // Mixed strobe, heavy noise
        run(SRCH_LEN + 30, 7, 30, 60, 0);
        @(posedge clk);
        #3;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d left req=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
